multi_pulse_gen: RTL and testbench
==================================

Name: multi_pulse_gen

Overview:
Parametrised multi-channel successor to the single one-shot generator. Each channel detects a programmable edge (rising, falling or both) on its trigger input and emits a pulse with a programmable length in clock cycles. The block adds an optional input synchroniser, optional retrigger and a sticky per-channel missed-edge flag. It sits between asynchronous or bus-side event sources (bit-timing events, error strobes, host commands) and the CAN controller logic, which consumes fixed-length strobes.

Parameters:
NUM_CH, 4, number of independent channels (1..32)
LEN_W, 8, width of pulse_len; max pulse length 2^LEN_W-1 cycles
SYNC_EN, 1, 1 = 2-flop synchroniser on every trigger bit; 0 = trigger used directly

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
trigger  input  NUM_CH  per-channel trigger inputs
enable  input  NUM_CH  per-channel enable
edge_mode  input  2  00 rising, 01 falling, 10 both, 11 reserved (behaves as rising); shared by all channels
pulse_len  input  LEN_W  pulse length in cycles; 0 treated as 1
retrig  input  1  1 = edge during active pulse restarts the length count
clear_missed  input  1  synchronous clear of all missed flags
pulse_out  output  NUM_CH  registered pulse outputs
missed  output  NUM_CH  sticky flag: an edge was dropped on this channel

Behaviour:
- Reset is asynchronous and active-high. All of the following clear immediately: pulse_out, missed, per-channel counters, synchroniser flops and previous-sample flops.
- Trigger path: t_s = trigger after SYNC_EN*2 register stages. prev = t_s registered one cycle.
- Edge detect per channel: rise = t_s & ~prev; fall = ~t_s & prev.
  - edge = rise (mode 00/11), fall (01) or rise|fall (10).
  - prev resets to 0, so a trigger held high through reset release produces one rising edge. This matches the existing one-shot behaviour.
- Latency, SYNC_EN=0: trigger high before clk edge k (low before k-1) gives pulse_out high after edge k.
- Latency, SYNC_EN=1: pulse_out rises 2 cycles later (after edge k+2).
- Pulse length: L = max(pulse_len,1). L is captured at pulse start; changes mid-pulse do not affect the running pulse. pulse_out is high for exactly L consecutive cycles.
- Per-channel state: IDLE (cnt=0, pulse_out=0) and ACTIVE (cnt>0, pulse_out=1).
  - IDLE, edge & enable: load cnt=L, go to ACTIVE.
  - ACTIVE: cnt decrements each cycle; pulse_out drops the cycle after cnt reaches its last count.
  - ACTIVE, edge & enable & retrig: reload cnt=L (current pulse_len). The pulse stays high with no gap; missed is not set.
  - ACTIVE, edge & enable & ~retrig: edge ignored, missed set. This includes an edge on the final active cycle.
- enable low:
  - counter cleared and pulse_out low on the next edge; edges ignored; missed not set.
  - prev keeps tracking, so re-enabling while the trigger is held high does not fire.
- missed: set by a dropped edge, cleared by clear_missed. If set and clear occur in the same cycle, set wins. Sticky otherwise.
- edge_mode change takes effect on the next cycle's edge detection. No spurious edge is generated by the mode change itself.
- Channels are fully independent. Simultaneous edges on all channels are each serviced in the same cycle.
- Reset asserted mid-pulse: pulse_out drops immediately (asynchronously). No pulse resumes after release unless a new edge is detected.

Test Plan:
- SYNC_EN=0, mode 00, pulse_len=3, ch0 trigger 0→1 held high → pulse_out[0] high exactly 3 cycles starting the cycle after the sampling edge; no further pulse while held; missed=0.
- SYNC_EN=1, mode 10, pulse_len=0, ch1 one rising then one falling edge 5 cycles apart → two 1-cycle pulses, each 3 cycles after its trigger change.
- pulse_len=4, retrig=0, second rising edge on ch2 two cycles into pulse → pulse lasts 4 cycles total, missed[2]=1. Then clear_missed=1 → missed[2]=0 next cycle. Repeat with retrig=1 → pulse high 6 cycles continuously, missed stays 0.
- Edge on cycle where missed set and clear_missed both occur → missed remains 1.
- enable[3]=0 during edges → no pulse, no missed. Raise enable while trigger high → no pulse. Drop enable mid-pulse → pulse_out[3] low next cycle.
- Trigger held high across reset release → one pulse after the first clock. Reset asserted mid-pulse → pulse_out=0 immediately, no pulse after release until a new edge.

Source files
------------

// File: rtl/multi_pulse_gen.sv
// multi_pulse_gen: per-channel programmable-edge one-shot with optional retrigger and sticky missed-edge flag.
// Latency: pulse_out rises after the clock edge that samples the trigger edge (two cycles later with SYNC_EN=1).
// Backpressure: none; an edge during a running pulse either restarts it (retrig) or is dropped and sets missed.
//
// Ports:
//   clk, reset        clock (rising edge) and asynchronous active-high reset
//   trigger, enable   per-channel trigger input and channel enable
//   edge_mode         00 rise, 01 fall, 10 both, 11 rise; shared by all channels
//   pulse_len         pulse length in cycles (0 behaves as 1), captured at pulse start
//   retrig            edge during an active pulse reloads the length count
//   clear_missed      synchronous clear of all missed flags (a same-cycle set wins)
//   pulse_out, missed registered per-channel pulse and sticky dropped-edge flag
module multi_pulse_gen #(
    parameter int NUM_CH  = 4,
    parameter int LEN_W   = 8,
    parameter int SYNC_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] trigger,
    input  logic [NUM_CH-1:0] enable,
    input  logic [1:0]        edge_mode,
    input  logic [LEN_W-1:0]  pulse_len,
    input  logic              retrig,
    input  logic              clear_missed,
    output logic [NUM_CH-1:0] pulse_out,
    output logic [NUM_CH-1:0] missed
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [NUM_CH-1:0] trig_s;
    logic [NUM_CH-1:0] trig_prev;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] edge_det;
    logic [LEN_W-1:0]  len_eff;

    generate
        if (SYNC_EN != 0) begin : g_sync
            logic [NUM_CH-1:0] sync_meta;
            logic [NUM_CH-1:0] sync_out;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_meta <= '0;
                    sync_out  <= '0;
                end else begin
                    sync_meta <= trigger;
                    sync_out  <= sync_meta;
                end
            end

            assign trig_s = sync_out;
        end else begin : g_nosync
            assign trig_s = trigger;
        end
    endgenerate

    // prev keeps tracking even while a channel is disabled, so enabling a
    // channel whose trigger is already high does not look like an edge.
    // Resetting it to 0 makes a trigger held high through reset fire once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_prev <= '0;
        end else begin
            trig_prev <= trig_s;
        end
    end

    assign rise = trig_s & ~trig_prev;
    assign fall = ~trig_s & trig_prev;

    always_comb begin
        case (edge_mode)
            2'b01:   edge_det = fall;
            2'b10:   edge_det = rise | fall;
            default: edge_det = rise;
        endcase
    end

    assign len_eff = (pulse_len == '0) ? LEN_W'(1) : pulse_len;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            state_t           state_q;
            state_t           state_d;
            logic [LEN_W-1:0] cnt_q;
            logic [LEN_W-1:0] cnt_d;
            logic             missed_q;
            logic             missed_d;
            logic             drop;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    missed_q <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    cnt_q    <= cnt_d;
                    missed_q <= missed_d;
                end
            end

            // cnt holds the number of high cycles still owed, counting the
            // current one; the pulse ends on the edge that sees cnt == 1.
            always_comb begin
                state_d  = state_q;
                cnt_d    = cnt_q;
                missed_d = missed_q;
                drop     = 1'b0;

                if (!enable[i]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (edge_det[i]) begin
                                state_d = ACTIVE;
                                cnt_d   = len_eff;
                            end
                        end
                        ACTIVE: begin
                            if (edge_det[i] && retrig) begin
                                cnt_d = len_eff;
                            end else begin
                                drop = edge_det[i];
                                if (cnt_q == LEN_W'(1)) begin
                                    state_d = IDLE;
                                    cnt_d   = '0;
                                end else begin
                                    cnt_d = cnt_q - LEN_W'(1);
                                end
                            end
                        end
                        default: begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    endcase
                end

                if (drop) begin
                    missed_d = 1'b1;
                end else if (clear_missed) begin
                    missed_d = 1'b0;
                end
            end

            assign pulse_out[i] = (state_q == ACTIVE);
            assign missed[i]    = missed_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_pulse_gen.sv
// tb_multi_pulse_gen: scoreboard bench driving a direct-trigger and a synchronised instance in parallel.
// Latency: reference model predicts outputs after each clock edge; monitor compares on the falling edge.
// Backpressure: not applicable; outputs are compared every cycle.
module tb_multi_pulse_gen;

    localparam int NCH = 4;
    localparam int LW  = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] trigger;
    logic [NCH-1:0] enable;
    logic [1:0]     edge_mode;
    logic [LW-1:0]  pulse_len;
    logic           retrig;
    logic           clear_missed;
    logic [NCH-1:0] p0, m0, p1, m1;

    always #5 clk = ~clk;

    multi_pulse_gen #(.NUM_CH(NCH), .LEN_W(LW), .SYNC_EN(0)) dut0 (
        .clk(clk), .reset(reset), .trigger(trigger), .enable(enable),
        .edge_mode(edge_mode), .pulse_len(pulse_len), .retrig(retrig),
        .clear_missed(clear_missed), .pulse_out(p0), .missed(m0)
    );

    multi_pulse_gen #(.NUM_CH(NCH), .LEN_W(LW), .SYNC_EN(1)) dut1 (
        .clk(clk), .reset(reset), .trigger(trigger), .enable(enable),
        .edge_mode(edge_mode), .pulse_len(pulse_len), .retrig(retrig),
        .clear_missed(clear_missed), .pulse_out(p1), .missed(m1)
    );

    typedef struct packed {
        logic [NCH-1:0] p;
        logic [NCH-1:0] m;
    } obs_t;

    obs_t           q0[$];
    obs_t           q1[$];
    logic [NCH-1:0] hist[$];     // trigger value seen at each clock edge since reset
    int             rem[2][NCH]; // high cycles still owed per channel
    bit             mis[2][NCH];
    int             hi_cnt[2][NCH];
    int             vectors;
    int             miscompares;

    function automatic logic [NCH-1:0] t_at(int idx);
        if (idx < 0) return '0;
        return hist[idx];
    endfunction

    // Reference: the trigger the channel sees is the raw trigger delayed by d
    // edges; a pulse is simply a count of cycles still owed.
    function automatic obs_t model_step(int k, int d);
        obs_t           o;
        int             idx;
        int             len;
        logic [NCH-1:0] ts, pv, rs, fl, ed;
        idx = hist.size() - 1;
        ts  = t_at(idx - d);
        pv  = t_at(idx - d - 1);
        rs  = ts & ~pv;
        fl  = ~ts & pv;
        if (edge_mode == 2'b01)      ed = fl;
        else if (edge_mode == 2'b10) ed = rs | fl;
        else                         ed = rs;
        len = (pulse_len == '0) ? 1 : int'(pulse_len);
        for (int c = 0; c < NCH; c++) begin
            bit set_m;
            set_m = 1'b0;
            if (!enable[c]) begin
                rem[k][c] = 0;
            end else if (rem[k][c] == 0) begin
                if (ed[c]) rem[k][c] = len;
            end else if (ed[c] && retrig) begin
                rem[k][c] = len;
            end else begin
                if (ed[c]) set_m = 1'b1;
                rem[k][c] = rem[k][c] - 1;
            end
            if (set_m)             mis[k][c] = 1'b1;
            else if (clear_missed) mis[k][c] = 1'b0;
            o.p[c] = (rem[k][c] > 0);
            o.m[c] = mis[k][c];
        end
        return o;
    endfunction

    task automatic model_loop();
        forever begin
            @(posedge clk);
            if (reset) begin
                hist.delete();
                for (int k = 0; k < 2; k++)
                    for (int c = 0; c < NCH; c++) begin
                        rem[k][c] = 0;
                        mis[k][c] = 1'b0;
                    end
            end else begin
                hist.push_back(trigger);
                q0.push_back(model_step(0, 0));
                q1.push_back(model_step(1, 2));
            end
        end
    endtask

    task automatic monitor_loop();
        obs_t e;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (p0[c] === 1'b1) hi_cnt[0][c]++;
                if (p1[c] === 1'b1) hi_cnt[1][c]++;
            end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                vectors++;
                if (p0 !== e.p || m0 !== e.m) begin
                    miscompares++;
                    $display("FAIL nosync t=%0t pulse_out=%b missed=%b expected pulse_out=%b missed=%b",
                             $time, p0, m0, e.p, e.m);
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                vectors++;
                if (p1 !== e.p || m1 !== e.m) begin
                    miscompares++;
                    $display("FAIL sync t=%0t pulse_out=%b missed=%b expected pulse_out=%b missed=%b",
                             $time, p1, m1, e.p, e.m);
                end
            end
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Outputs must drop asynchronously, before any clock edge.
    task automatic reset_check();
        reset = 1'b1;
        #1;
        vectors++;
        if (p0 !== '0 || m0 !== '0 || p1 !== '0 || m1 !== '0) begin
            miscompares++;
            $display("FAIL async_reset t=%0t pulse_out=%b/%b missed=%b/%b expected all zero",
                     $time, p0, p1, m0, m1);
        end
    endtask

    task automatic clear_win();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NCH; c++) hi_cnt[k][c] = 0;
    endtask

    task automatic check_width(string name, int k, int c, int exp_cycles);
        vectors++;
        if (hi_cnt[k][c] != exp_cycles) begin
            miscompares++;
            $display("FAIL %s high_cycles=%0d expected %0d", name, hi_cnt[k][c], exp_cycles);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        trigger      = '0;
        enable       = '1;
        edge_mode    = 2'b00;
        pulse_len    = LW'(3);
        retrig       = 1'b0;
        clear_missed = 1'b0;
        clear_win();
        fork
            model_loop();
            monitor_loop();
        join_none

        reset_check();
        tick(3);
        reset = 1'b0;
        tick(2);

        // Rising edge held high, length 3: exactly one 3-cycle pulse.
        clear_win();
        trigger[0] = 1'b1;
        tick(10);
        check_width("len3_nosync", 0, 0, 3);
        check_width("len3_sync", 1, 0, 3);
        trigger[0] = 1'b0;
        tick(3);

        // Both-edge mode, length 0 behaves as 1.
        edge_mode = 2'b10;
        pulse_len = '0;
        clear_win();
        trigger[1] = 1'b1;
        tick(5);
        trigger[1] = 1'b0;
        tick(6);
        check_width("len0_both_nosync", 0, 1, 2);
        check_width("len0_both_sync", 1, 1, 2);

        // Second edge two cycles into a 4-cycle pulse, no retrigger.
        edge_mode = 2'b00;
        pulse_len = LW'(4);
        clear_win();
        trigger[2] = 1'b1; tick(1);
        trigger[2] = 1'b0; tick(1);
        trigger[2] = 1'b1; tick(1);
        trigger[2] = 1'b0; tick(8);
        check_width("drop_nosync", 0, 2, 4);
        clear_missed = 1'b1; tick(1);
        clear_missed = 1'b0; tick(2);

        // Same pattern with retrigger: 6 continuous cycles.
        retrig = 1'b1;
        clear_win();
        trigger[2] = 1'b1; tick(1);
        trigger[2] = 1'b0; tick(1);
        trigger[2] = 1'b1; tick(1);
        trigger[2] = 1'b0; tick(10);
        check_width("retrig_nosync", 0, 2, 6);
        check_width("retrig_sync", 1, 2, 6);

        // Dropped edge coincident with clear_missed: set wins.
        retrig = 1'b0;
        trigger[2] = 1'b1; tick(1);
        trigger[2] = 1'b0; tick(1);
        trigger[2] = 1'b1; clear_missed = 1'b1; tick(1);
        clear_missed = 1'b0; trigger[2] = 1'b0; tick(6);
        clear_missed = 1'b1; tick(3);
        clear_missed = 1'b0;

        // Enable handling on ch3.
        enable[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            trigger[3] = ~trigger[3];
            tick(2);
        end
        trigger[3] = 1'b1; tick(3);
        enable[3]  = 1'b1; tick(5);
        trigger[3] = 1'b0; tick(3);
        pulse_len  = LW'(6);
        trigger[3] = 1'b1; tick(4);
        enable[3]  = 1'b0; tick(3);
        enable[3]  = 1'b1; trigger[3] = 1'b0; tick(3);

        // Reset mid-pulse, then trigger held high across release.
        trigger[0] = 1'b1; tick(4);
        reset_check();
        trigger[0] = 1'b0; tick(2);
        reset = 1'b0; tick(8);
        reset_check();
        trigger[0] = 1'b1; tick(2);
        reset = 1'b0; tick(10);

        // Randomised traffic.
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 5) == 0)  trigger[c] = ~trigger[c];
                if ($urandom_range(0, 60) == 0) enable[c]  = ~enable[c];
            end
            if ($urandom_range(0, 40) == 0) edge_mode = 2'($urandom);
            if ($urandom_range(0, 20) == 0)
                pulse_len = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(7, 20))
                                                        : LW'($urandom_range(0, 6));
            if ($urandom_range(0, 25) == 0) retrig = ~retrig;
            clear_missed = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 500) == 0) begin
                reset_check();
                tick(2);
                reset = 1'b0;
            end
            tick(1);
        end

        clear_missed = 1'b0;
        tick(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
